// File: rtl/lin_curve_pkg.sv
// Shared widths, table-select encoding and swap FSM states for the
// lin_curves table storage.
package lin_curve_pkg;

    localparam int SEG_AW_DEF = 5;
    localparam int AW         = 1 + 2 + SEG_AW_DEF;
    localparam int OFFSET_W   = 16;
    localparam int SLOPE_W    = 11;

    localparam logic TBL_OFFSET = 1'b0;
    localparam logic TBL_SLOPE  = 1'b1;

    typedef enum logic {
        SW_IDLE,
        SW_PENDING
    } swap_state_e;

endpackage

// File: rtl/dpram_1r1w.sv
// Simple dual-port RAM: synchronous write, registered read-first read.
// Contents are never reset; only the read register is.
module dpram_1r1w #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Non-blocking read of the pre-write array gives read-first on collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lin_curve_tables.sv
// Double-buffered offset/slope tables for lin_curves: host writes the shadow
// bank, and the active bank flips only on a qphase 3->0 frame boundary.
module lin_curve_tables
    import lin_curve_pkg::*;
#(
    parameter int  SEG_AW  = SEG_AW_DEF,
    parameter int  TIMEOUT = 1024,
    localparam int TAW     = 3 + SEG_AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          qphase,
    input  logic [TAW-1:0]      offset_rom_addr,
    input  logic [TAW-1:0]      slope_rom_addr,
    output logic [OFFSET_W-1:0] offset_rom,
    output logic [SLOPE_W-1:0]  slope_rom,
    output logic                bank,
    input  logic                lb_write,
    input  logic [TAW:0]        lb_addr,
    input  logic [15:0]         lb_data,
    input  logic                swap_req,
    output logic                swap_pending,
    output logic                swap_done,
    output logic                wr_reject,
    output logic                swap_err,
    input  logic                clr_flags
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    swap_state_e      state_q;
    logic             bank_q;
    logic             swap_done_q;
    logic             swap_err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       qph_q;
    logic             boundary;

    logic             wr_ok;
    logic             wr_en_d, wr_en_q;
    logic             wr_reject_d, wr_reject_q;
    logic             wr_tbl_q;
    logic [TAW-1:0]   wr_addr_q;
    logic [15:0]      wr_data_q;

    assign boundary = (qphase == 2'd0) && (qph_q == 2'd3);

    // Writes may only touch the shadow bank, and never while a flip is armed.
    always_comb begin
        wr_ok       = lb_write && (lb_addr[TAW-1] != bank_q) && (state_q == SW_IDLE);
        wr_en_d     = wr_ok;
        wr_reject_d = wr_reject_q;
        if (clr_flags) begin
            wr_reject_d = 1'b0;
        end
        if (lb_write && !wr_ok) begin
            wr_reject_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q     <= 1'b0;
            wr_reject_q <= 1'b0;
            qph_q       <= 2'd0;
        end else begin
            wr_en_q     <= wr_en_d;
            wr_reject_q <= wr_reject_d;
            qph_q       <= qphase;
        end
    end

    always_ff @(posedge clk) begin
        wr_tbl_q  <= lb_addr[TAW];
        wr_addr_q <= lb_addr[TAW-1:0];
        wr_data_q <= lb_data;
    end

    // Swap FSM: a request arms PENDING; the flip or the timeout retires it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SW_IDLE;
            bank_q      <= 1'b0;
            cnt_q       <= '0;
            swap_done_q <= 1'b0;
            swap_err_q  <= 1'b0;
        end else begin
            swap_done_q <= 1'b0;
            if (clr_flags) begin
                swap_err_q <= 1'b0;
            end
            case (state_q)
                SW_IDLE: begin
                    cnt_q <= '0;
                    if (swap_req) begin
                        state_q <= SW_PENDING;
                    end
                end
                SW_PENDING: begin
                    if (boundary) begin
                        state_q     <= SW_IDLE;
                        bank_q      <= ~bank_q;
                        swap_done_q <= 1'b1;
                        cnt_q       <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= SW_IDLE;
                        swap_err_q <= 1'b1;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= SW_IDLE;
            endcase
        end
    end

    dpram_1r1w #(
        .DW (OFFSET_W),
        .AW (TAW)
    ) u_offset_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_en_q && (wr_tbl_q == TBL_OFFSET)),
        .waddr_i (wr_addr_q),
        .wdata_i (wr_data_q),
        .raddr_i (offset_rom_addr),
        .rdata_o (offset_rom)
    );

    // Slope entries keep only the low SLOPE_W bits of the host word.
    dpram_1r1w #(
        .DW (SLOPE_W),
        .AW (TAW)
    ) u_slope_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_en_q && (wr_tbl_q == TBL_SLOPE)),
        .waddr_i (wr_addr_q),
        .wdata_i (wr_data_q[SLOPE_W-1:0]),
        .raddr_i (slope_rom_addr),
        .rdata_o (slope_rom)
    );

    assign bank         = bank_q;
    assign swap_pending = (state_q == SW_PENDING);
    assign swap_done    = swap_done_q;
    assign swap_err     = swap_err_q;
    assign wr_reject    = wr_reject_q;

endmodule

// File: tb/tb_lin_curve_tables.sv
// Scoreboard bench for lin_curve_tables: table writes, bank swaps, timeout,
// sticky flags and reset behaviour.
module tb_lin_curve_tables;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  qphase;
    logic [7:0]  offset_rom_addr;
    logic [7:0]  slope_rom_addr;
    logic [15:0] offset_rom;
    logic [10:0] slope_rom;
    logic        bank;
    logic        lb_write;
    logic [8:0]  lb_addr;
    logic [15:0] lb_data;
    logic        swap_req;
    logic        swap_pending;
    logic        swap_done;
    logic        wr_reject;
    logic        swap_err;
    logic        clr_flags;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic        qrun   = 1'b0;
    logic        exp_bank = 1'b0;
    logic        exp_pend = 1'b0;

    logic [15:0] off_m [256];
    logic [10:0] slp_m [256];
    logic [15:0] sb_exp [$];
    string       sb_tag [$];

    lin_curve_tables #(
        .SEG_AW  (5),
        .TIMEOUT (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .qphase          (qphase),
        .offset_rom_addr (offset_rom_addr),
        .slope_rom_addr  (slope_rom_addr),
        .offset_rom      (offset_rom),
        .slope_rom       (slope_rom),
        .bank            (bank),
        .lb_write        (lb_write),
        .lb_addr         (lb_addr),
        .lb_data         (lb_data),
        .swap_req        (swap_req),
        .swap_pending    (swap_pending),
        .swap_done       (swap_done),
        .wr_reject       (wr_reject),
        .swap_err        (swap_err),
        .clr_flags       (clr_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (qrun) qphase = qphase + 2'd1;
    endtask

    task automatic wr(input logic tbl, input logic [7:0] a, input logic [15:0] d);
        lb_write = 1'b1;
        lb_addr  = {tbl, a};
        lb_data  = d;
        if ((a[7] != exp_bank) && !exp_pend) begin
            if (tbl) slp_m[a] = d[10:0];
            else     off_m[a] = d;
        end
        tick();
        lb_write = 1'b0;
        tick();
    endtask

    task automatic rd(input logic tbl, input logic [7:0] a, input string tag);
        logic [15:0] got;
        if (tbl) begin
            slope_rom_addr = a;
            sb_exp.push_back({5'd0, slp_m[a]});
        end else begin
            offset_rom_addr = a;
            sb_exp.push_back(off_m[a]);
        end
        sb_tag.push_back(tag);
        tick();
        got = tbl ? {5'd0, slope_rom} : offset_rom;
        check(sb_tag.pop_front(), got, sb_exp.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        rst_n = 1'b0;
        qphase = 2'd0;
        offset_rom_addr = 8'd0;
        slope_rom_addr = 8'd0;
        lb_write = 1'b0;
        lb_addr = 9'd0;
        lb_data = 16'd0;
        swap_req = 1'b0;
        clr_flags = 1'b0;
        repeat (3) tick();

        check("rst_bank", 16'(bank), 16'd0);
        check("rst_pending", 16'(swap_pending), 16'd0);
        check("rst_done", 16'(swap_done), 16'd0);
        check("rst_wr_reject", 16'(wr_reject), 16'd0);
        check("rst_swap_err", 16'(swap_err), 16'd0);
        check("rst_offset_rom", offset_rom, 16'd0);
        check("rst_slope_rom", 16'(slope_rom), 16'd0);
        rst_n = 1'b1;
        tick();

        // Bank 0 active: fill shadow bank 1, and try to write the active bank.
        wr(1'b0, 8'hA5, 16'h1234);
        wr(1'b1, 8'h85, 16'hFC00);
        check("shadow_ok_no_reject", 16'(wr_reject), 16'd0);
        wr(1'b0, 8'h25, 16'h5555);
        check("active_wr_reject", 16'(wr_reject), 16'd1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("clr_wr_reject", 16'(wr_reject), 16'd0);
        rd(1'b0, 8'hA5, "shadow_read_offset");

        // Swap requested mid-frame flips on the next 3->0.
        qrun = 1'b1;
        for (int i = 0; i < 8 && qphase != 2'd1; i++) tick();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("swap1_pending", 16'(swap_pending), 16'd1);
        tick();
        tick();
        check("swap1_bank_before", 16'(bank), 16'd0);
        check("swap1_done_before", 16'(swap_done), 16'd0);
        tick();
        check("swap1_bank_after", 16'(bank), 16'd1);
        check("swap1_done_pulse", 16'(swap_done), 16'd1);
        check("swap1_pending_clr", 16'(swap_pending), 16'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (swap_done === 1'b1) pulses++;
        end
        check("swap1_single_pulse", 16'(pulses), 16'd0);
        check("swap1_bank_stable", 16'(bank), 16'd1);
        exp_bank = 1'b1;

        // Bank 1 active.
        rd(1'b0, 8'hA5, "bank1_offset_a5");
        rd(1'b1, 8'h85, "bank1_slope_neg1024");
        wr(1'b0, 8'h25, 16'hBEEF);
        check("bank0_wr_accept", 16'(wr_reject), 16'd0);
        wr(1'b0, 8'hA6, 16'h1111);
        check("bank1_wr_reject", 16'(wr_reject), 16'd1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("clr_again", 16'(wr_reject), 16'd0);
        lb_write = 1'b1;
        lb_addr = {1'b0, 8'hA7};
        lb_data = 16'h2222;
        clr_flags = 1'b1;
        tick();
        lb_write = 1'b0;
        clr_flags = 1'b0;
        check("set_beats_clr", 16'(wr_reject), 16'd1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;

        // Swap requested on the boundary cycle waits a whole frame.
        for (int i = 0; i < 8 && qphase != 2'd0; i++) tick();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("swap2_pending", 16'(swap_pending), 16'd1);
        tick();
        tick();
        tick();
        check("swap2_bank_hold", 16'(bank), 16'd1);
        check("swap2_still_pending", 16'(swap_pending), 16'd1);
        tick();
        check("swap2_bank_after", 16'(bank), 16'd0);
        check("swap2_done_pulse", 16'(swap_done), 16'd1);
        exp_bank = 1'b0;

        rd(1'b0, 8'h25, "bank0_offset_25");
        wr(1'b0, 8'hA5, 16'h7777);
        rd(1'b0, 8'h25, "bank0_unchanged_25");
        rd(1'b0, 8'hA5, "shadow_new_a5");

        // qphase frozen: swap must time out and leave the bank alone.
        qrun = 1'b0;
        qphase = 2'd2;
        tick();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        exp_pend = 1'b1;
        wr(1'b0, 8'h90, 16'h3333);
        check("pending_wr_reject", 16'(wr_reject), 16'd1);
        check("to_pending_early", 16'(swap_pending), 16'd1);
        repeat (13) tick();
        check("to_pending_last", 16'(swap_pending), 16'd1);
        check("to_no_err_yet", 16'(swap_err), 16'd0);
        tick();
        exp_pend = 1'b0;
        check("to_pending_drop", 16'(swap_pending), 16'd0);
        check("to_swap_err", 16'(swap_err), 16'd1);
        check("to_bank_same", 16'(bank), 16'd0);
        check("to_no_done", 16'(swap_done), 16'd0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("clr_swap_err", 16'(swap_err), 16'd0);
        check("clr_wr_reject2", 16'(wr_reject), 16'd0);

        // Reset while a swap is pending from bank 1.
        qrun = 1'b1;
        for (int i = 0; i < 8 && qphase != 2'd1; i++) tick();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        for (int i = 0; i < 8 && bank !== 1'b1; i++) tick();
        check("pre_rst_bank1", 16'(bank), 16'd1);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("pre_rst_pending", 16'(swap_pending), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_bank", 16'(bank), 16'd0);
        check("async_rst_pending", 16'(swap_pending), 16'd0);
        tick();
        rst_n = 1'b1;
        exp_bank = 1'b0;
        repeat (5) tick();
        check("post_rst_bank", 16'(bank), 16'd0);
        check("post_rst_pending", 16'(swap_pending), 16'd0);
        rd(1'b0, 8'h25, "ram_kept_25");
        rd(1'b0, 8'hA5, "ram_kept_a5");
        rd(1'b1, 8'h85, "ram_kept_slope");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
